// File: rtl/midi_pkg.sv
// Shared MIDI constants: status ranges, message-length lookup, receiver and parser state encodings.
package midi_pkg;

  localparam logic [2:0] U_IDLE  = 3'd0;
  localparam logic [2:0] U_START = 3'd1;
  localparam logic [2:0] U_DATA  = 3'd2;
  localparam logic [2:0] U_STOP  = 3'd3;
  localparam logic [2:0] U_WAIT  = 3'd4;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_DATA  = 2'd1;
  localparam logic [1:0] P_SYSEX = 2'd2;

  localparam logic [7:0] SYS_MIN  = 8'hF0;
  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  // Total message length including the status byte; 0 means the status carries no message.
  function automatic logic [1:0] msg_len(input logic [7:0] st);
    logic [1:0] len;
    len = 2'd0;
    if (st < SYS_MIN) begin
      len = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 2'd2 : 2'd3;
    end else begin
      case (st)
        8'hF1, 8'hF3: len = 2'd2;
        8'hF2:        len = 2'd3;
        8'hF6:        len = 2'd1;
        default:      len = 2'd0;
      endcase
    end
    return len;
  endfunction

  function automatic logic is_rt(input logic [7:0] b);
    return b >= RT_MIN;
  endfunction

  function automatic logic is_chan(input logic [7:0] b);
    return b[7] && (b[7:4] != 4'hF);
  endfunction

endpackage

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 receiver: synchroniser, free-running baud tick, byte FSM.
// byte_vld/frame_err are combinational strobes on the stop-bit sample tick; no backpressure.
module uart_rx_os
  import midi_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 31250,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W = $clog2(OVS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [2:0]             state_q, state_d;
  logic [OVS_W-1:0]       ovs_cnt_q, ovs_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tick;
  logic                   rx;

  assign rx      = sync_q[SYNC_STAGES-1];
  assign tick    = (div_cnt_q == DIV_LAST);
  assign rx_byte = shift_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    state_d   = state_q;
    ovs_cnt_d = ovs_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    if (tick) begin
      case (state_q)
        U_IDLE: begin
          if (!rx) begin
            state_d   = U_START;
            ovs_cnt_d = '0;
          end
        end
        U_START: begin
          // Half a bit after the edge: a still-low line is a real start bit.
          if (ovs_cnt_q == OVS_MID) begin
            ovs_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = rx ? U_IDLE : U_DATA;
          end else begin
            ovs_cnt_d = ovs_cnt_q + 1'b1;
          end
        end
        U_DATA: begin
          if (ovs_cnt_q == OVS_LAST) begin
            ovs_cnt_d = '0;
            shift_d   = {rx, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = U_STOP;
          end else begin
            ovs_cnt_d = ovs_cnt_q + 1'b1;
          end
        end
        U_STOP: begin
          if (ovs_cnt_q == OVS_LAST) begin
            ovs_cnt_d = '0;
            byte_vld  = rx;
            frame_err = !rx;
            state_d   = rx ? U_IDLE : U_WAIT;
          end else begin
            ovs_cnt_d = ovs_cnt_q + 1'b1;
          end
        end
        U_WAIT: begin
          if (rx) state_d = U_IDLE;
        end
        default: state_d = U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      div_cnt_q <= '0;
      state_q   <= U_IDLE;
      ovs_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      ovs_cnt_q <= ovs_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input: oversampling receiver plus running-status message parser with a separate real-time path.
// Pulses land one cycle after the stop-bit sample tick; no backpressure, each pulse must be taken.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 31250,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MIDI_IN,
  output logic [23:0] MIDI_MSG,
  output logic [1:0]  MIDI_LEN,
  output logic        MIDI_MSG_RDY,
  output logic [7:0]  RT_BYTE,
  output logic        RT_RDY,
  output logic        FRAME_ERR
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx_os #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVS        (OVS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uart (
    .clk      (CLK),
    .rst      (RST),
    .rx_in    (MIDI_IN),
    .rx_byte  (rx_byte),
    .byte_vld (rx_vld),
    .frame_err(rx_ferr)
  );

  logic [1:0]  pst_q, pst_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  need_q, need_d;
  logic [1:0]  have_q, have_d;
  logic [7:0]  d1_q, d1_d;
  logic [23:0] msg_q, msg_d;
  logic [1:0]  len_q, len_d;
  logic        msg_rdy_q, msg_rdy_d;
  logic [7:0]  rt_byte_q, rt_byte_d;
  logic        rt_rdy_q, rt_rdy_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    pst_d     = pst_q;
    status_d  = status_q;
    need_d    = need_q;
    have_d    = have_q;
    d1_d      = d1_q;
    msg_d     = msg_q;
    len_d     = len_q;
    msg_rdy_d = 1'b0;
    rt_byte_d = rt_byte_q;
    rt_rdy_d  = 1'b0;
    ferr_d    = rx_ferr;
    if (rx_ferr) begin
      // Drop the partial message; a channel status survives as running status.
      if (pst_q == P_DATA) begin
        have_d = 2'd1;
        if (!is_chan(status_q)) pst_d = P_IDLE;
      end
    end else if (rx_vld) begin
      if (is_rt(rx_byte)) begin
        rt_byte_d = rx_byte;
        rt_rdy_d  = 1'b1;
      end else if (rx_byte[7]) begin
        status_d = rx_byte;
        need_d   = msg_len(rx_byte);
        have_d   = 2'd1;
        if (rx_byte == ST_SYSEX) begin
          pst_d = P_SYSEX;
        end else if (msg_len(rx_byte) == 2'd1) begin
          msg_d     = {rx_byte, 16'h0000};
          len_d     = 2'd1;
          msg_rdy_d = 1'b1;
          pst_d     = P_IDLE;
        end else if (msg_len(rx_byte) == 2'd0) begin
          pst_d = P_IDLE;
        end else begin
          pst_d = P_DATA;
        end
      end else if (pst_q == P_DATA) begin
        if (have_q == 2'd1 && need_q == 2'd3) begin
          d1_d   = rx_byte;
          have_d = 2'd2;
        end else begin
          msg_d     = (have_q == 2'd1) ? {status_q, rx_byte, 8'h00} : {status_q, d1_q, rx_byte};
          len_d     = need_q;
          msg_rdy_d = 1'b1;
          have_d    = 2'd1;
          if (!is_chan(status_q)) pst_d = P_IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pst_q     <= P_IDLE;
      status_q  <= '0;
      need_q    <= '0;
      have_q    <= '0;
      d1_q      <= '0;
      msg_q     <= '0;
      len_q     <= '0;
      msg_rdy_q <= 1'b0;
      rt_byte_q <= '0;
      rt_rdy_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      pst_q     <= pst_d;
      status_q  <= status_d;
      need_q    <= need_d;
      have_q    <= have_d;
      d1_q      <= d1_d;
      msg_q     <= msg_d;
      len_q     <= len_d;
      msg_rdy_q <= msg_rdy_d;
      rt_byte_q <= rt_byte_d;
      rt_rdy_q  <= rt_rdy_d;
      ferr_q    <= ferr_d;
    end
  end

  assign MIDI_MSG     = msg_q;
  assign MIDI_LEN     = len_q;
  assign MIDI_MSG_RDY = msg_rdy_q;
  assign RT_BYTE      = rt_byte_q;
  assign RT_RDY       = rt_rdy_q;
  assign FRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: directed vector table, hand-built corner sequences, random stream vs queue model.
module tb_midi_rx_parser;

  localparam int CLK_HZ  = 500000;
  localparam int BAUD    = 31250;
  localparam int OVS     = 8;
  localparam int BIT_CYC = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst;
  logic        midi_in;
  logic [23:0] midi_msg;
  logic [1:0]  midi_len;
  logic        midi_msg_rdy;
  logic [7:0]  rt_byte;
  logic        rt_rdy;
  logic        frame_err;

  always #5 clk = ~clk;

  midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .SYNC_STAGES(2)) dut (
    .CLK(clk), .RST(rst), .MIDI_IN(midi_in), .MIDI_MSG(midi_msg), .MIDI_LEN(midi_len),
    .MIDI_MSG_RDY(midi_msg_rdy), .RT_BYTE(rt_byte), .RT_RDY(rt_rdy), .FRAME_ERR(frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_stop_cyc = 0;
  int last_msg_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed traffic
  logic [25:0] got_msg[$];
  logic [7:0]  got_rt[$];
  int          got_ferr = 0;
  logic        prev_msg = 1'b0, prev_rt = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (midi_msg_rdy) begin
      got_msg.push_back({midi_msg, midi_len});
      last_msg_cyc = cyc;
      check("msg_rdy_back_to_back", prev_msg, 1'b0);
    end
    if (rt_rdy) begin
      got_rt.push_back(rt_byte);
      check("rt_rdy_back_to_back", prev_rt, 1'b0);
    end
    if (frame_err) begin
      got_ferr++;
      check("frame_err_back_to_back", prev_fe, 1'b0);
    end
    prev_msg = midi_msg_rdy;
    prev_rt  = rt_rdy;
    prev_fe  = frame_err;
  end

  // Reference model: the pending message is a byte queue, running status a single byte.
  logic [25:0] exp_msg[$];
  logic [7:0]  exp_rt[$];
  int          exp_ferr = 0;
  logic [7:0]  m_buf[$];
  logic [7:0]  m_rs = 8'h00;

  function automatic int ref_len(input logic [7:0] s);
    if (s >= 8'h80 && s <= 8'hBF) return 3;
    if (s >= 8'hC0 && s <= 8'hDF) return 2;
    if (s >= 8'hE0 && s <= 8'hEF) return 3;
    if (s == 8'hF1 || s == 8'hF3) return 2;
    if (s == 8'hF2) return 3;
    if (s == 8'hF6) return 1;
    return 0;
  endfunction

  task automatic model_emit();
    logic [23:0] m;
    m = '0;
    for (int i = 0; i < m_buf.size(); i++) m[23-8*i -: 8] = m_buf[i];
    exp_msg.push_back({m, 2'(m_buf.size())});
    m_buf.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_buf.delete();
      exp_ferr++;
    end else if (b >= 8'hF8) begin
      exp_rt.push_back(b);
    end else if (b >= 8'h80) begin
      m_buf.delete();
      m_rs = (b < 8'hF0) ? b : 8'h00;
      if (ref_len(b) > 0) begin
        m_buf.push_back(b);
        if (ref_len(b) == 1) model_emit();
      end
    end else begin
      if (m_buf.size() == 0 && m_rs != 8'h00) m_buf.push_back(m_rs);
      if (m_buf.size() > 0) begin
        m_buf.push_back(b);
        if (m_buf.size() == ref_len(m_buf[0])) model_emit();
      end
    end
  endtask

  task automatic clear_q();
    got_msg.delete(); got_rt.delete(); got_ferr = 0;
    exp_msg.delete(); exp_rt.delete(); exp_ferr = 0;
    m_buf.delete(); m_rs = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    midi_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge clk);
    midi_in = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    last_stop_cyc = cyc;
    midi_in = good;
    repeat (BIT_CYC) @(negedge clk);
    midi_in = 1'b1;
    if (!good) repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nmsg"}, got_msg.size(), exp_msg.size());
    for (int i = 0; i < got_msg.size() && i < exp_msg.size(); i++)
      check($sformatf("%s_msg%0d", tag, i), got_msg[i], exp_msg[i]);
    check({tag, "_nrt"}, got_rt.size(), exp_rt.size());
    for (int i = 0; i < got_rt.size() && i < exp_rt.size(); i++)
      check($sformatf("%s_rt%0d", tag, i), got_rt[i], exp_rt[i]);
    check({tag, "_nferr"}, got_ferr, exp_ferr);
  endtask

  typedef struct packed {
    logic [47:0] bytes;
    logic [2:0]  n;
    logic [1:0]  n_msg;
    logic [25:0] first;
    logic [25:0] last;
    logic [1:0]  n_rt;
    logic [7:0]  rt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{48'h903C64000000, 3'd3, 2'd1, {24'h903C64, 2'd3}, {24'h903C64, 2'd3}, 2'd0, 8'h00};
    vecs[1]  = '{48'hC5070A000000, 3'd3, 2'd2, {24'hC50700, 2'd2}, {24'hC50A00, 2'd2}, 2'd0, 8'h00};
    vecs[2]  = '{48'h903CF8640000, 3'd4, 2'd1, {24'h903C64, 2'd3}, {24'h903C64, 2'd3}, 2'd1, 8'hF8};
    vecs[3]  = '{48'hF07E01F74000, 3'd5, 2'd0, 26'h0, 26'h0, 2'd0, 8'h00};
    vecs[4]  = '{48'hF11213000000, 3'd3, 2'd1, {24'hF11200, 2'd2}, {24'hF11200, 2'd2}, 2'd0, 8'h00};
    vecs[5]  = '{48'hF60000000000, 3'd1, 2'd1, {24'hF60000, 2'd1}, {24'hF60000, 2'd1}, 2'd0, 8'h00};
    vecs[6]  = '{48'hF20102000000, 3'd3, 2'd1, {24'hF20102, 2'd3}, {24'hF20102, 2'd3}, 2'd0, 8'h00};
    vecs[7]  = '{48'h903CD3050000, 3'd4, 2'd1, {24'hD30500, 2'd2}, {24'hD30500, 2'd2}, 2'd0, 8'h00};
    vecs[8]  = '{48'hF440F5410000, 3'd4, 2'd0, 26'h0, 26'h0, 2'd0, 8'h00};
    vecs[9]  = '{48'hB0077F086000, 3'd5, 2'd2, {24'hB0077F, 2'd3}, {24'hB00860, 2'd3}, 2'd0, 8'h00};
    vecs[10] = '{48'hFF0000000000, 3'd1, 2'd0, 26'h0, 26'h0, 2'd1, 8'hFF};
    vecs[11] = '{48'hE00040FE0102, 3'd6, 2'd2, {24'hE00040, 2'd3}, {24'hE00102, 2'd3}, 2'd1, 8'hFE};

    rst = 1'b1;
    midi_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_msg", midi_msg, 24'h0);
    check("rst_len", midi_len, 2'd0);
    check("rst_msg_rdy", midi_msg_rdy, 1'b0);
    check("rst_rt_byte", rt_byte, 8'h0);
    check("rst_rt_rdy", rt_rdy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    for (int v = 0; v < 12; v++) begin
      logic [47:0] bb;
      do_reset();
      bb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].n); i++) send_byte(bb[47-8*i -: 8], 1'b1);
      settle();
      check($sformatf("v%0d_nmsg", v), got_msg.size(), vecs[v].n_msg);
      if (vecs[v].n_msg != 0) begin
        check($sformatf("v%0d_first", v), got_msg.size() > 0 ? got_msg[0] : 26'h3FFFFFF, vecs[v].first);
        check($sformatf("v%0d_last", v), got_msg.size() > 0 ? got_msg[got_msg.size()-1] : 26'h3FFFFFF, vecs[v].last);
      end
      check($sformatf("v%0d_held_msg", v), {midi_msg, midi_len}, vecs[v].last);
      check($sformatf("v%0d_nrt", v), got_rt.size(), vecs[v].n_rt);
      check($sformatf("v%0d_held_rt", v), rt_byte, vecs[v].rt);
      check($sformatf("v%0d_nferr", v), got_ferr, 0);
      if (v == 0) begin
        int d;
        d = last_msg_cyc - last_stop_cyc;
        check("v0_latency_in_stop_bit", (d >= 8 && d <= 14), 1'b1);
      end
    end

    // Bad stop bit, then a tune request
    do_reset();
    send_byte(8'h55, 1'b0);
    settle();
    check("ferr_count", got_ferr, 1);
    check("ferr_nmsg", got_msg.size(), 0);
    send_byte(8'hF6, 1'b1);
    settle();
    check("ferr_then_f6_nmsg", got_msg.size(), 1);
    check("ferr_then_f6_msg", got_msg.size() > 0 ? got_msg[0] : 26'h3FFFFFF, {24'hF60000, 2'd1});

    // Frame error mid-message keeps running status
    do_reset();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h40, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    settle();
    check("ferr_rs_nmsg", got_msg.size(), 2);
    check("ferr_rs_msg0", got_msg.size() > 0 ? got_msg[0] : 26'h3FFFFFF, {24'h904041, 2'd3});
    check("ferr_rs_msg1", got_msg.size() > 1 ? got_msg[1] : 26'h3FFFFFF, {24'h904243, 2'd3});
    check("ferr_rs_nferr", got_ferr, 1);

    // One-tick low glitch on an idle line
    do_reset();
    @(negedge clk);
    midi_in = 1'b0;
    repeat (2) @(negedge clk);
    midi_in = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_nmsg", got_msg.size(), 0);
    check("glitch_nrt", got_rt.size(), 0);
    check("glitch_nferr", got_ferr, 0);
    send_byte(8'hC5, 1'b1);
    send_byte(8'h07, 1'b1);
    settle();
    check("glitch_after_msg", got_msg.size() > 0 ? got_msg[0] : 26'h3FFFFFF, {24'hC50700, 2'd2});

    // Reset in the middle of a data bit
    do_reset();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'hF8, 1'b1);
    settle();
    check("pre_rst_msg", {midi_msg, midi_len}, {24'h903C64, 2'd3});
    @(negedge clk);
    midi_in = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    midi_in = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    midi_in = 1'b0;
    repeat (BIT_CYC / 2) @(negedge clk);
    rst = 1'b1;
    midi_in = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_msg", midi_msg, 24'h0);
    check("midrst_len", midi_len, 2'd0);
    check("midrst_msg_rdy", midi_msg_rdy, 1'b0);
    check("midrst_rt_byte", rt_byte, 8'h0);
    check("midrst_rt_rdy", rt_rdy, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    clear_q();
    repeat (40) @(negedge clk);
    send_byte(8'h80, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    check("midrst_after_nmsg", got_msg.size(), 1);
    check("midrst_after_msg", got_msg.size() > 0 ? got_msg[0] : 26'h3FFFFFF, {24'h804000, 2'd3});
    check("midrst_after_nrt", got_rt.size(), 0);
    check("midrst_after_nferr", got_ferr, 0);

    // Random byte stream against the model
    do_reset();
    for (int k = 0; k < 80; k++) begin
      int r;
      logic [7:0] b;
      bit good;
      r = $urandom_range(0, 99);
      good = 1'b1;
      if (r < 20)      b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 28) b = 8'($urandom_range(8'hF0, 8'hF7));
      else if (r < 36) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 92) b = 8'($urandom_range(0, 8'h7F));
      else begin
        b = 8'($urandom);
        good = 1'b0;
      end
      model_byte(b, good);
      send_byte(b, good);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    settle();
    compare_all("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
